ppu_host_port: RTL and testbench



---
 rtl/ppu_pkg.sv | 33 +++
 rtl/ppu_host_port_if.sv | 19 +
 rtl/ppu_vram_slot.sv | 80 ++++++++
 rtl/ppu_host_port.sv | 160 ++++++++++++++++
 tb/tb_ppu_host_port.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU host port: register indices, VRAM op
// FSM states and the posted VRAM operation record.
package ppu_pkg;

  localparam int VRAM_AW = 14;
  localparam int INC_ROW = 32;
  localparam int INC_COL = 1;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_MASK   = 3'd1,
    REG_STATUS = 3'd2,
    REG_RSVD3  = 3'd3,
    REG_RSVD4  = 3'd4,
    REG_SCROLL = 3'd5,
    REG_ADDR   = 3'd6,
    REG_DATA   = 3'd7
  } host_reg_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACCESS  = 2'd2,
    CAPTURE = 2'd3
  } op_state_e;

  typedef struct packed {
    logic               wr;
    logic [VRAM_AW-1:0] addr;
    logic [7:0]         data;
  } vram_op_t;

endpackage

// File: rtl/ppu_host_port_if.sv
// CPU-side register window of the PPU: 3-bit index, read/write strobes and
// the write and registered read data buses.
interface ppu_host_port_if;
  logic [2:0] I_host_addr;
  logic       I_host_wren;
  logic       I_host_rden;
  logic [7:0] I_host_data;
  logic [7:0] O_host_data;

  modport master (
    output I_host_addr, I_host_wren, I_host_rden, I_host_data,
    input  O_host_data
  );

  modport slave (
    input  I_host_addr, I_host_wren, I_host_rden, I_host_data,
    output O_host_data
  );
endinterface

// File: rtl/ppu_vram_slot.sv
// One-deep host VRAM operation: latches a posted op, waits for a pixel slot
// the renderer leaves free, drives the VRAM port and captures read data.
module ppu_vram_slot
  import ppu_pkg::*;
(
  input  logic               I_clock,
  input  logic               I_reset,
  input  logic               post,
  input  vram_op_t           op_in,
  input  logic               I_vid_rise,
  input  logic               I_render_busy,
  input  logic [7:0]         I_vid_data,
  output logic               busy,
  output logic               done,
  output logic [7:0]         rd_data,
  output logic [VRAM_AW-1:0] vid_addr,
  output logic               vid_wren,
  output logic [7:0]         vid_data
);

  op_state_e          state_reg, state_next;
  vram_op_t           op_reg;
  logic               grant;
  logic [VRAM_AW-1:0] vid_addr_reg;
  logic               vid_wren_reg;
  logic [7:0]         vid_data_reg;

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state_reg <= IDLE;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && post)
        op_reg <= op_in;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    case (state_reg)
      IDLE:    if (post) state_next = WAIT;
      WAIT: begin
        if (I_vid_rise && !I_render_busy) begin
          grant      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = op_reg.wr ? IDLE : CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Port registers load on the grant edge so the access lands in grant+1;
  // the address then holds until the next grant.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      vid_addr_reg <= '0;
      vid_wren_reg <= 1'b0;
      vid_data_reg <= '0;
    end else begin
      vid_wren_reg <= grant & op_reg.wr;
      if (grant) begin
        vid_addr_reg <= op_reg.addr;
        if (op_reg.wr)
          vid_data_reg <= op_reg.data;
      end
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == CAPTURE);
  assign rd_data  = I_vid_data;
  assign vid_addr = vid_addr_reg;
  assign vid_wren = vid_wren_reg;
  assign vid_data = vid_data_reg;

endmodule

// File: rtl/ppu_host_port.sv
// PPU host port: CPU register window, vblank/NMI and VRAM access scheduling.
// Optional open-bus latch enabled by defining PPU_OPEN_BUS_EN.
module ppu_host_port
  import ppu_pkg::*;
#(
  parameter int ADDR_W = VRAM_AW
) (
  input  logic              I_clock,
  input  logic              I_reset,
  ppu_host_port_if.slave    host,
  input  logic              I_vid_rise,
  input  logic              I_render_busy,
  input  logic              I_vblank_set,
  input  logic              I_vblank_clr,
  output logic              O_host_nmi,
  output logic [ADDR_W-1:0] O_vid_addr,
  output logic              O_vid_wren,
  output logic [7:0]        O_vid_data,
  input  logic [7:0]        I_vid_data,
  output logic [7:0]        O_ctrl,
  output logic [7:0]        O_mask,
  output logic [7:0]        O_scroll_x,
  output logic [7:0]        O_scroll_y,
  output logic              O_busy
);

  logic [7:0]         ctrl_reg, ctrl_next, mask_reg, scroll_x_reg, scroll_y_reg;
  logic [ADDR_W-1:0]  t_reg, t_inc;
  logic               w_reg, vblank_reg, vblank_next, nmi_reg;
  logic [7:0]         host_data_reg, rd_buf_reg, rd_val, open_val;
  logic               wr_stb, rd_stb, status_rd, data_acc, post, vblank_rd;
  logic               slot_busy, slot_done, slot_wren;
  logic [7:0]         slot_rdata, slot_wdata;
  logic [VRAM_AW-1:0] slot_addr;
  vram_op_t           op;

  always_comb begin
    // A simultaneous write and read is treated as a write only.
    wr_stb    = host.I_host_wren;
    rd_stb    = host.I_host_rden & ~host.I_host_wren;
    status_rd = rd_stb && (host.I_host_addr == REG_STATUS);
    data_acc  = (wr_stb || rd_stb) && (host.I_host_addr == REG_DATA);
    post      = data_acc & ~slot_busy;
    t_inc     = t_reg + (ctrl_reg[2] ? ADDR_W'(INC_ROW) : ADDR_W'(INC_COL));

    ctrl_next = ctrl_reg;
    if (wr_stb && host.I_host_addr == REG_CTRL)
      ctrl_next = host.I_host_data;

    // A set arriving with the STATUS read wins: the read misses it, the flag stays.
    vblank_rd   = vblank_reg & ~I_vblank_set;
    vblank_next = vblank_reg;
    if (I_vblank_set)
      vblank_next = 1'b1;
    else if (I_vblank_clr || status_rd)
      vblank_next = 1'b0;

    case (host.I_host_addr)
      REG_STATUS: rd_val = {vblank_rd, 2'b00, open_val[4:0]};
      REG_DATA:   rd_val = rd_buf_reg;
      default:    rd_val = open_val;
    endcase

    op.wr   = wr_stb;
    op.addr = VRAM_AW'(t_reg);
    op.data = host.I_host_data;
  end

`ifdef PPU_OPEN_BUS_EN
  logic [7:0] open_bus_reg;

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset)
      open_bus_reg <= '0;
    else if (wr_stb)
      open_bus_reg <= host.I_host_data;
    else if (rd_stb)
      open_bus_reg <= rd_val;
  end

  assign open_val = open_bus_reg;
`else
  assign open_val = 8'h00;
`endif

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      ctrl_reg      <= '0;
      mask_reg      <= '0;
      scroll_x_reg  <= '0;
      scroll_y_reg  <= '0;
      t_reg         <= '0;
      w_reg         <= 1'b0;
      vblank_reg    <= 1'b0;
      nmi_reg       <= 1'b0;
      host_data_reg <= '0;
      rd_buf_reg    <= '0;
    end else begin
      ctrl_reg   <= ctrl_next;
      vblank_reg <= vblank_next;
      nmi_reg    <= vblank_next & ctrl_next[7];
      if (status_rd)
        w_reg <= 1'b0;
      if (rd_stb)
        host_data_reg <= rd_val;
      if (slot_done)
        rd_buf_reg <= slot_rdata;
      if (post)
        t_reg <= t_inc;
      if (wr_stb) begin
        case (host.I_host_addr)
          REG_MASK: mask_reg <= host.I_host_data;
          REG_SCROLL: begin
            if (!w_reg)
              scroll_x_reg <= host.I_host_data;
            else
              scroll_y_reg <= host.I_host_data;
            w_reg <= ~w_reg;
          end
          REG_ADDR: begin
            if (!w_reg)
              t_reg[ADDR_W-1:8] <= host.I_host_data[ADDR_W-9:0];
            else
              t_reg[7:0] <= host.I_host_data;
            w_reg <= ~w_reg;
          end
          default: ;
        endcase
      end
    end
  end

  ppu_vram_slot u_slot (
    .I_clock       (I_clock),
    .I_reset       (I_reset),
    .post          (post),
    .op_in         (op),
    .I_vid_rise    (I_vid_rise),
    .I_render_busy (I_render_busy),
    .I_vid_data    (I_vid_data),
    .busy          (slot_busy),
    .done          (slot_done),
    .rd_data       (slot_rdata),
    .vid_addr      (slot_addr),
    .vid_wren      (slot_wren),
    .vid_data      (slot_wdata)
  );

  assign host.O_host_data = host_data_reg;
  assign O_host_nmi       = nmi_reg;
  assign O_vid_addr       = ADDR_W'(slot_addr);
  assign O_vid_wren       = slot_wren;
  assign O_vid_data       = slot_wdata;
  assign O_ctrl           = ctrl_reg;
  assign O_mask           = mask_reg;
  assign O_scroll_x       = scroll_x_reg;
  assign O_scroll_y       = scroll_y_reg;
  assign O_busy           = slot_busy;

endmodule

// File: tb/tb_ppu_host_port.sv
// Directed bench for ppu_host_port: register window, VRAM write/read slots,
// dropped accesses, vblank/NMI and reset abort, against a small VRAM model.
module tb_ppu_host_port;

  logic        I_clock = 1'b0;
  logic        I_reset = 1'b0;
  logic        I_vid_rise = 1'b0;
  logic        I_render_busy = 1'b0;
  logic        I_vblank_set = 1'b0;
  logic        I_vblank_clr = 1'b0;
  logic        O_host_nmi;
  logic [13:0] O_vid_addr;
  logic        O_vid_wren;
  logic [7:0]  O_vid_data;
  logic [7:0]  I_vid_data;
  logic [7:0]  O_ctrl, O_mask, O_scroll_x, O_scroll_y;
  logic        O_busy;

  ppu_host_port_if hif ();

  ppu_host_port #(.ADDR_W(14)) dut (
    .I_clock       (I_clock),
    .I_reset       (I_reset),
    .host          (hif),
    .I_vid_rise    (I_vid_rise),
    .I_render_busy (I_render_busy),
    .I_vblank_set  (I_vblank_set),
    .I_vblank_clr  (I_vblank_clr),
    .O_host_nmi    (O_host_nmi),
    .O_vid_addr    (O_vid_addr),
    .O_vid_wren    (O_vid_wren),
    .O_vid_data    (O_vid_data),
    .I_vid_data    (I_vid_data),
    .O_ctrl        (O_ctrl),
    .O_mask        (O_mask),
    .O_scroll_x    (O_scroll_x),
    .O_scroll_y    (O_scroll_y),
    .O_busy        (O_busy)
  );

  always #5 I_clock = ~I_clock;

  // Pixel-clock slot strobe: one I_clock in four, changed away from the active edge.
  logic [1:0] div_cnt = 2'd0;
  always @(negedge I_clock) begin
    div_cnt    = div_cnt + 2'd1;
    I_vid_rise = (div_cnt == 2'd0);
  end

  // VRAM model with one-cycle read latency, plus a write-pulse monitor.
  logic [7:0]  mem [0:16383];
  logic [7:0]  vram_q = 8'h00;
  int          wren_cnt = 0;
  logic [13:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  assign I_vid_data = vram_q;

  initial for (int i = 0; i < 16384; i++) mem[i] = 8'h00;

  always @(posedge I_clock) begin
    if (O_vid_wren === 1'b1) begin
      wren_cnt++;
      last_addr = O_vid_addr;
      last_data = O_vid_data;
      mem[O_vid_addr] <= O_vid_data;
    end
    vram_q <= mem[O_vid_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge I_clock);
    hif.I_host_addr = a; hif.I_host_data = d; hif.I_host_wren = 1'b1;
    @(negedge I_clock);
    hif.I_host_wren = 1'b0;
  endtask

  task automatic host_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge I_clock);
    hif.I_host_addr = a; hif.I_host_rden = 1'b1;
    @(negedge I_clock);
    hif.I_host_rden = 1'b0;
    d = hif.O_host_data;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (O_busy !== 1'b0 && n < budget) begin
      @(negedge I_clock);
      n++;
    end
    check({tag, " idle"}, {15'd0, O_busy}, 16'd0);
  endtask

  task automatic data_write(input logic [7:0] d);
    host_write(3'd7, d);
    wait_idle("wr", 40);
  endtask

  task automatic set_addr(input logic [7:0] hi, input logic [7:0] lo);
    host_write(3'd6, hi);
    host_write(3'd6, lo);
  endtask

  task automatic pulse_set();
    @(negedge I_clock); I_vblank_set = 1'b1;
    @(negedge I_clock); I_vblank_set = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge I_clock); I_vblank_clr = 1'b1;
    @(negedge I_clock); I_vblank_clr = 1'b0;
  endtask

  logic [7:0] rd;
  int         c0;

  initial begin
    hif.I_host_addr = 3'd0; hif.I_host_data = 8'h00;
    hif.I_host_wren = 1'b0; hif.I_host_rden = 1'b0;

    // Reset state
    repeat (3) @(negedge I_clock);
    check("rst host_data", {8'h00, hif.O_host_data}, 16'h0000);
    check("rst vid", {1'b0, O_vid_wren, O_vid_addr}, 16'h0000);
    check("rst cfg", {O_ctrl, O_mask}, 16'h0000);
    check("rst scroll", {O_scroll_x, O_scroll_y}, 16'h0000);
    check("rst nmi/busy", {14'd0, O_host_nmi, O_busy}, 16'h0000);
    I_reset = 1'b1;

    // ADDR 0x2108 then a DATA write
    set_addr(8'h21, 8'h08);
    host_write(3'd7, 8'h5A);
    check("posted busy", {15'd0, O_busy}, 16'h0001);
    wait_idle("wr1", 40);
    check("wr1 count", 16'(wren_cnt), 16'd1);
    check("wr1 addr", {2'b00, last_addr}, 16'h2108);
    check("wr1 data", {8'h00, last_data}, 16'h005A);
    check("vid_addr hold", {2'b00, O_vid_addr}, 16'h2108);
    data_write(8'h77);
    check("t after wr1", {2'b00, last_addr}, 16'h2109);

    // +32 increment with 14-bit wrap
    host_write(3'd0, 8'h04);
    check("ctrl", {8'h00, O_ctrl}, 16'h0004);
    set_addr(8'h3F, 8'hF0);
    data_write(8'hA5);
    check("row addr", {2'b00, last_addr}, 16'h3FF0);
    data_write(8'hB6);
    check("row wrap", {2'b00, last_addr}, 16'h0010);

    // +1 increment with 14-bit wrap
    host_write(3'd0, 8'h00);
    set_addr(8'h3F, 8'hFF);
    data_write(8'hC1);
    check("col addr", {2'b00, last_addr}, 16'h3FFF);
    data_write(8'hC2);
    check("col wrap", {2'b00, last_addr}, 16'h0000);

    // Buffered DATA reads
    set_addr(8'h20, 8'h00);
    data_write(8'h11); data_write(8'h22); data_write(8'h33);
    set_addr(8'h20, 8'h00);
    host_read(3'd7, rd); check("rd1 reset buf", {8'h00, rd}, 16'h0000);
    wait_idle("rd1", 8);
    host_read(3'd7, rd); check("rd2", {8'h00, rd}, 16'h0011);
    wait_idle("rd2", 8);
    host_read(3'd7, rd); check("rd3", {8'h00, rd}, 16'h0022);
    wait_idle("rd3", 8);
    repeat (5) @(negedge I_clock);
    check("host_data hold", {8'h00, hif.O_host_data}, 16'h0022);

    // Renderer holds VRAM: second write and a read are dropped
    I_render_busy = 1'b1;
    set_addr(8'h01, 8'h00);
    c0 = wren_cnt;
    host_write(3'd7, 8'h3C);
    host_write(3'd7, 8'h44);
    host_read(3'd7, rd); check("dropped rd buf", {8'h00, rd}, 16'h0033);
    repeat (40) @(negedge I_clock);
    check("blocked busy", {15'd0, O_busy}, 16'h0001);
    check("blocked no wren", 16'(wren_cnt - c0), 16'd0);
    I_render_busy = 1'b0;
    wait_idle("unblock", 8);
    check("unblock count", 16'(wren_cnt - c0), 16'd1);
    check("unblock addr", {2'b00, last_addr}, 16'h0100);
    check("unblock data", {8'h00, last_data}, 16'h003C);
    data_write(8'h55);
    check("t after drop", {2'b00, last_addr}, 16'h0101);

    // vblank and NMI
    host_write(3'd0, 8'h80);
    pulse_set();
    check("nmi on set", {15'd0, O_host_nmi}, 16'h0001);
    host_read(3'd2, rd); check("status vblank", {8'h00, rd}, 16'h0080);
    check("nmi after read", {15'd0, O_host_nmi}, 16'h0000);
    host_read(3'd2, rd); check("status cleared", {8'h00, rd}, 16'h0000);
    host_write(3'd0, 8'h00);
    pulse_set();
    check("nmi masked", {15'd0, O_host_nmi}, 16'h0000);
    host_write(3'd0, 8'h80);
    check("nmi late enable", {15'd0, O_host_nmi}, 16'h0001);
    pulse_clr();
    check("nmi on clr", {15'd0, O_host_nmi}, 16'h0000);

    // STATUS read coinciding with vblank set
    host_write(3'd0, 8'h00);
    @(negedge I_clock);
    hif.I_host_addr = 3'd2; hif.I_host_rden = 1'b1; I_vblank_set = 1'b1;
    @(negedge I_clock);
    hif.I_host_rden = 1'b0; I_vblank_set = 1'b0;
    check("race read", {8'h00, hif.O_host_data}, 16'h0000);
    host_read(3'd2, rd); check("race flag kept", {8'h00, rd}, 16'h0080);

    // STATUS read clears the write toggle; MASK and reserved index
    host_write(3'd5, 8'h12);
    host_read(3'd2, rd);
    host_write(3'd5, 8'h34);
    host_write(3'd5, 8'h56);
    check("scroll xy", {O_scroll_x, O_scroll_y}, 16'h3456);
    host_write(3'd1, 8'h1E);
    check("mask", {8'h00, O_mask}, 16'h001E);
    host_write(3'd3, 8'hFF);
    host_read(3'd3, rd); check("rsvd read", {8'h00, rd}, 16'h0000);

    // Simultaneous write and read: the write wins
    @(negedge I_clock);
    hif.I_host_addr = 3'd1; hif.I_host_data = 8'h6B;
    hif.I_host_wren = 1'b1; hif.I_host_rden = 1'b1;
    @(negedge I_clock);
    hif.I_host_wren = 1'b0; hif.I_host_rden = 1'b0;
    check("wr+rd mask", {8'h00, O_mask}, 16'h006B);
    check("wr+rd no read", {8'h00, hif.O_host_data}, 16'h0000);

    // Reset while an op waits for a slot
    I_render_busy = 1'b1;
    set_addr(8'h02, 8'h00);
    host_write(3'd7, 8'h99);
    check("pre-reset busy", {15'd0, O_busy}, 16'h0001);
    c0 = wren_cnt;
    @(negedge I_clock);
    I_reset = 1'b0;
    #1;
    check("mid rst busy/nmi/wren", {13'd0, O_busy, O_host_nmi, O_vid_wren}, 16'h0000);
    check("mid rst vid", {2'b00, O_vid_addr}, 16'h0000);
    check("mid rst cfg", {O_ctrl, O_mask}, 16'h0000);
    check("mid rst scroll", {O_scroll_x, O_scroll_y}, 16'h0000);
    check("mid rst data", {O_vid_data, hif.O_host_data}, 16'h0000);
    repeat (3) @(negedge I_clock);
    I_render_busy = 1'b0;
    I_reset = 1'b1;
    repeat (12) @(negedge I_clock);
    check("no write after rst", 16'(wren_cnt - c0), 16'd0);
    check("idle after rst", {15'd0, O_busy}, 16'h0000);
    host_read(3'd7, rd); check("buf after rst", {8'h00, rd}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
